// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/write-back with a memory ready handshake.
module multicycle_control (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State,
    output logic       IllegalOp
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEMADDR   = 4'd2,
        MEMRD     = 4'd3,
        MEMWB     = 4'd4,
        MEMWR     = 4'd5,
        EXEC      = 4'd6,
        RDONE     = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDIEXEC  = 4'd10,
        ADDIDONE  = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t st;
    logic   lw_q;
    logic   ill_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            st    <= FETCH;
            lw_q  <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            case (st)
                FETCH:    if (MemReady) st <= DECODE;
                DECODE: begin
                    lw_q <= (Opcode == OP_LW);
                    case (Opcode)
                        OP_R:          st <= EXEC;
                        OP_LW, OP_SW:  st <= MEMADDR;
                        OP_BEQ:        st <= BRANCH;
                        OP_J:          st <= JUMP;
                        OP_ADDI:       st <= ADDIEXEC;
                        default: begin
                            st    <= FETCH;
                            ill_q <= 1'b1;
                        end
                    endcase
                end
                MEMADDR:  st <= lw_q ? MEMRD : MEMWR;
                MEMRD:    if (MemReady) st <= MEMWB;
                MEMWR:    if (MemReady) st <= FETCH;
                EXEC:     st <= RDONE;
                ADDIEXEC: st <= ADDIDONE;
                default:  st <= FETCH;
            endcase
        end
    end

    // Reset overrides the decode so no enable survives into the reset cycle.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        if (!reset) begin
            case (st)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                DECODE:   ALUSrcB = 2'b11;
                MEMADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                RDONE: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                ADDIEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                ADDIDONE: RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

    assign State     = reset ? 4'd0 : st;
    assign IllegalOp = ill_q & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control.
// Expected per-cycle traces are built from instruction class and stall counts.
module tb_multicycle_control;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Opcode = 6'd0;
    logic       MemReady = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;
    logic       IllegalOp;
    logic [17:0] outs;

    int total = 0;
    int bad = 0;
    bit exp_ill = 1'b0;
    int eq_s[$];
    bit eq_m[$];

    multicycle_control dut (
        .clock(clock), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .State(State), .IllegalOp(IllegalOp)
    );

    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                   IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    always #5 clock = ~clock;

    function automatic logic [17:0] exp_out(int s, bit mr);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0;
        logic irw = 0, rw = 0, rdst = 0, asa = 0;
        logic [1:0] asb = 0, aop = 0, psrc = 0;
        case (s)
            0: begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            1: asb = 2'b11;
            2: begin asa = 1; asb = 2'b10; end
            3: begin mrd = 1; iord = 1; end
            4: begin rw = 1; m2r = 1; end
            5: begin mwr = 1; iord = 1; end
            6: begin asa = 1; aop = 2'b10; end
            7: begin rw = 1; rdst = 1; end
            8: begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
            9: begin pcw = 1; psrc = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, asa, asb, aop, psrc};
    endfunction

    function automatic bit is_legal(logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011,
                          6'b000100, 6'b000010, 6'b001000};
    endfunction

    function automatic void add_wait(int st, int n);
        for (int k = 0; k < n; k++) begin
            eq_s.push_back(st);
            eq_m.push_back(1'b0);
        end
        eq_s.push_back(st);
        eq_m.push_back(1'b1);
    endfunction

    function automatic void add(int st);
        eq_s.push_back(st);
        eq_m.push_back(1'($urandom));
    endfunction

    function automatic void build(logic [5:0] op, int sf, int sm);
        eq_s.delete();
        eq_m.delete();
        add_wait(0, sf);
        add(1);
        case (op)
            6'b000000: begin add(6); add(7); end
            6'b100011: begin add(2); add_wait(3, sm); add(4); end
            6'b101011: begin add(2); add_wait(5, sm); end
            6'b000100: add(8);
            6'b000010: add(9);
            6'b001000: begin add(10); add(11); end
            default: ;
        endcase
    endfunction

    task automatic run_instr(string tag, logic [5:0] op, int sf, int sm, bit scramble);
        build(op, sf, sm);
        for (int i = 0; i < eq_s.size(); i++) begin
            @(negedge clock);
            MemReady = eq_m[i];
            Opcode = (eq_s[i] == 1 || !scramble) ? op : 6'($urandom);
            #1;
            total++;
            if (State !== 4'(eq_s[i]) || outs !== exp_out(eq_s[i], eq_m[i])
                || IllegalOp !== exp_ill) begin
                bad++;
                $display("FAIL %s op=%b cyc=%0d state=%0d want=%0d outs=%h want=%h ill=%b want=%b",
                         tag, op, i, State, eq_s[i], outs, exp_out(eq_s[i], eq_m[i]),
                         IllegalOp, exp_ill);
            end
            if (eq_s[i] == 1 && !is_legal(op)) exp_ill = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clock);
        #1;
        total++;
        if (outs !== 18'd0 || State !== 4'd0 || IllegalOp !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold outs=%h state=%0d ill=%b want 0", outs, State, IllegalOp);
        end
        @(negedge clock);
        reset = 1'b0;
        MemReady = 1'b0;
        #1;
        total++;
        if (State !== 4'd0 || outs !== exp_out(0, 0) || IllegalOp !== 1'b0) begin
            bad++;
            $display("FAIL reset_release state=%0d outs=%h want=%h ill=%b",
                     State, outs, exp_out(0, 0), IllegalOp);
        end
    endtask

    task automatic test_rtype;
        run_instr("rtype", 6'b000000, 0, 0, 1'b0);
    endtask

    task automatic test_lw_stall;
        run_instr("lw_stall", 6'b100011, 0, 2, 1'b0);
    endtask

    task automatic test_sw_beq_j;
        run_instr("sw", 6'b101011, 0, 0, 1'b0);
        run_instr("beq", 6'b000100, 0, 0, 1'b0);
        run_instr("j", 6'b000010, 0, 0, 1'b0);
    endtask

    task automatic test_fetch_stall;
        run_instr("fetch_stall", 6'b000000, 3, 0, 1'b0);
    endtask

    task automatic test_illegal;
        run_instr("illegal", 6'b111111, 0, 0, 1'b0);
        run_instr("addi_after_ill", 6'b001000, 0, 0, 1'b0);
    endtask

    task automatic test_random;
        logic [5:0] legal[6] = '{6'b000000, 6'b100011, 6'b101011,
                                  6'b000100, 6'b000010, 6'b001000};
        logic [5:0] op;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom); while (is_legal(op));
            end else begin
                op = legal[$urandom_range(0, 5)];
            end
            run_instr("random", op, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
        end
    endtask

    task automatic test_reset_midwb;
        run_instr("pre_wb", 6'b000000, 0, 0, 1'b0);
        Opcode = 6'b100011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            MemReady = 1'b1;
        end
        @(negedge clock);
        #1;
        total++;
        if (State !== 4'd4 || RegWrite !== 1'b1 || IllegalOp !== 1'b1) begin
            bad++;
            $display("FAIL midwb_reach state=%0d want=4 regwrite=%b ill=%b", State, RegWrite, IllegalOp);
        end
        reset = 1'b1;
        #1;
        total++;
        if (outs !== 18'd0 || State !== 4'd0 || IllegalOp !== 1'b0) begin
            bad++;
            $display("FAIL midwb_reset outs=%h state=%0d ill=%b want 0", outs, State, IllegalOp);
        end
        @(negedge clock);
        reset = 1'b0;
        MemReady = 1'b0;
        exp_ill = 1'b0;
        #1;
        total++;
        if (State !== 4'd0 || MemRead !== 1'b1 || IllegalOp !== 1'b0) begin
            bad++;
            $display("FAIL midwb_release state=%0d memread=%b ill=%b", State, MemRead, IllegalOp);
        end
        run_instr("post_reset", 6'b001000, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_rtype;
        test_lw_stall;
        test_sw_beq_j;
        test_fetch_stall;
        test_illegal;
        test_random;
        test_reset_midwb;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
